// File: rtl/bitwise_logic_pipe.sv
// rtl/bitwise_logic_pipe.sv - pipelined WIDTH-bit bitwise logic unit with accumulate mode and result flags
module bitwise_logic_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_accum,
   input  logic             in_last,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_all_ones,
   output logic             out_parity
);

   generate
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("bitwise_logic_pipe: STAGES must be in 1..4");
      end
   endgenerate

   logic [STAGES-1:0] valid_q, valid_d;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic              in_burst_q, in_burst_d;
   logic              zero_q, zero_d;
   logic              all_ones_q, all_ones_d;
   logic              parity_q, parity_d;

   logic              stall;
   logic              accept;
   logic [WIDTH-1:0]  x_opnd;
   logic [WIDTH-1:0]  op_result;

   always_comb begin
      stall    = valid_q[STAGES-1] & ~out_ready;
      in_ready = ~stall & ~reset;
      accept   = in_valid & in_ready;
      x_opnd   = (in_accum && in_burst_q) ? acc_q : in_a;

      case (in_op)
         3'd0:    op_result = x_opnd & in_b;
         3'd1:    op_result = x_opnd | in_b;
         3'd2:    op_result = x_opnd ^ in_b;
         3'd3:    op_result = ~(x_opnd | in_b);
         3'd4:    op_result = ~(x_opnd & in_b);
         3'd5:    op_result = ~(x_opnd ^ in_b);
         3'd6:    op_result = x_opnd & ~in_b;
         default: op_result = x_opnd;
      endcase

      valid_d    = valid_q;
      data_d     = data_q;
      acc_d      = acc_q;
      in_burst_d = in_burst_q;
      zero_d     = zero_q;
      all_ones_d = all_ones_q;
      parity_d   = parity_q;

      // Bubbles carry zero data so the gated flags of an empty final stage read as 0.
      if (!stall) begin
         valid_d[0] = accept;
         data_d[0]  = accept ? op_result : '0;
         for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
         zero_d     = valid_d[STAGES-1] & (data_d[STAGES-1] == '0);
         all_ones_d = valid_d[STAGES-1] & (&data_d[STAGES-1]);
         parity_d   = valid_d[STAGES-1] & (^data_d[STAGES-1]);
      end

      if (accept && in_accum) begin
         acc_d      = op_result;
         in_burst_d = ~in_last;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q    <= '0;
         data_q     <= '{default: '0};
         acc_q      <= '0;
         in_burst_q <= 1'b0;
         zero_q     <= 1'b0;
         all_ones_q <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         data_q     <= data_d;
         acc_q      <= acc_d;
         in_burst_q <= in_burst_d;
         zero_q     <= zero_d;
         all_ones_q <= all_ones_d;
         parity_q   <= parity_d;
      end
   end

   assign out_valid    = valid_q[STAGES-1];
   assign out_result   = data_q[STAGES-1];
   assign out_zero     = zero_q;
   assign out_all_ones = all_ones_q;
   assign out_parity   = parity_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb/tb_bitwise_logic_pipe.sv - scoreboard bench for bitwise_logic_pipe (WIDTH=32, STAGES=2)
module tb_bitwise_logic_pipe;

   localparam int W = 32;
   localparam int S = 2;

   logic         clock;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_op;
   logic         in_accum;
   logic         in_last;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_zero;
   logic         out_all_ones;
   logic         out_parity;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] mon_e;
   logic [W-1:0] m_acc;
   logic         m_burst;
   bit           rnd_done;

   bitwise_logic_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_accum(in_accum), .in_last(in_last), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_all_ones(out_all_ones), .out_parity(out_parity)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] b);
      case (op)
         3'd0:    return x & b;
         3'd1:    return x | b;
         3'd2:    return x ^ b;
         3'd3:    return ~(x | b);
         3'd4:    return ~(x & b);
         3'd5:    return ~(x ^ b);
         3'd6:    return x & ~b;
         default: return x;
      endcase
   endfunction

   // Monitor: any beat transferred out is compared with the oldest expected entry.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {32'd0, out_result}, 64'hDEAD_0000_0000_0000);
         end else begin
            mon_e = exp_q.pop_front();
            chk("beat", {29'd0, out_parity, out_all_ones, out_zero, out_result},
                {29'd0, ^mon_e, &mon_e, (mon_e == '0), mon_e});
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic acc, input logic last,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
      int n = 0;
      in_valid = 1'b1; in_op = op; in_accum = acc; in_last = last; in_a = a; in_b = b;
      @(negedge clock);
      while (!in_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
      else exp_q.push_back(e);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clock);
         n++;
      end
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_accum = 1'b0; in_last = 1'b0;
      in_a = '0; in_b = '0; out_ready = 1'b1; rnd_done = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_flags", {out_zero, out_all_ones, out_parity}, 0);
      chk("rst_in_ready", in_ready, 0);
      reset = 1'b0;

      // OR with exact two-cycle latency
      send(3'd1, 1'b0, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
      chk("lat_not_yet", out_valid, 0);
      @(posedge clock);
      #1;
      chk("lat_valid", out_valid, 1);
      chk("lat_result", out_result, 32'hF0F0_0F0F);

      send(3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
      send(3'd5, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF);
      send(3'd6, 1'b0, 1'b0, 32'hFFFF_00FF, 32'h0F0F_0F0F, 32'hF0F0_00F0);
      send(3'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_FFFF);
      send(3'd0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0000_FFFF, 32'h0000_F00D);
      send(3'd2, 1'b0, 1'b0, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA);

      // Accumulate OR burst then a single-beat burst reloading from A
      send(3'd1, 1'b1, 1'b0, 32'h1, 32'h2, 32'h3);
      send(3'd1, 1'b1, 1'b0, 32'hDEAD, 32'h4, 32'h7);
      send(3'd1, 1'b1, 1'b1, 32'hBEEF, 32'h8, 32'hF);
      send(3'd1, 1'b1, 1'b1, 32'h10, 32'h0, 32'h10);
      // Open burst survives an interleaved plain beat
      send(3'd1, 1'b1, 1'b0, 32'h100, 32'h1, 32'h101);
      send(3'd0, 1'b0, 1'b0, 32'hFF, 32'h0F, 32'h0F);
      send(3'd1, 1'b1, 1'b1, 32'h5A5A, 32'h2, 32'h103);
      drain();

      // Backpressure: four beats against a stalled output
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               send(3'd7, 1'b0, 1'b0, 32'hA0 + i, 32'h0, 32'hA0 + i);
            end
         end
         begin
            repeat (5) @(posedge clock);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            for (int k = 0; k < 3; k++) begin
               @(posedge clock);
               #1;
               chk("bp_hold", out_result, 32'hA0);
               chk("bp_in_ready_hold", in_ready, 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset in the middle of an open burst with the output stalled
      out_ready = 1'b0;
      send(3'd1, 1'b1, 1'b0, 32'hFF, 32'h0, 32'hFF);
      send(3'd7, 1'b0, 1'b0, 32'h77, 32'h0, 32'h77);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clock);
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_flags", {out_zero, out_all_ones, out_parity}, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      reset = 1'b0;
      out_ready = 1'b1;
      send(3'd1, 1'b1, 1'b1, 32'h5, 32'h30, 32'h35);
      drain();

      // Randomised traffic against the bench model
      m_acc = '0;
      m_burst = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [2:0]   op;
               logic         ac, la;
               logic [W-1:0] a, b, e;
               op = 3'($urandom_range(0, 7));
               ac = 1'($urandom_range(0, 1));
               la = ($urandom_range(0, 3) == 0);
               a  = $urandom;
               b  = $urandom;
               e  = model(op, (ac && m_burst) ? m_acc : a, b);
               send(op, ac, la, a, b, e);
               if (ac) begin
                  m_acc   = e;
                  m_burst = ~la;
               end
               if ($urandom_range(0, 3) == 0) begin
                  in_a = $urandom; in_b = $urandom; in_accum = 1'b1;
                  in_op = 3'($urandom_range(0, 7));
                  @(posedge clock);
                  #1;
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clock);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
